// File: rtl/insn_fetch_queue.sv
// Instruction fetch queue: circular buffer of {insn, pc, pred_taken} tuples
// between fetch and decode. Drains in program order over a valid/ready
// handshake; a flush from branch/jump resolution discards every entry.
// When the queue is empty, decode sees a NOP (ADDI x0,x0,0) with pc 0.

module insn_fetch_queue #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [XLEN-1:0]          enq_insn,
   input  logic [XLEN-1:0]          enq_pc,
   input  logic                     enq_pred_taken,
   output logic                     deq_valid,
   input  logic                     deq_ready,
   output logic [XLEN-1:0]          deq_insn,
   output logic [XLEN-1:0]          deq_pc,
   output logic                     deq_pred_taken,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [XLEN-1:0]  NOP_INSN = XLEN'(32'h0000_0013);

   logic [XLEN-1:0]  insn_mem [DEPTH];
   logic [XLEN-1:0]  pc_mem   [DEPTH];
   logic             pt_mem   [DEPTH];

   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic             enq_fire;
   logic             deq_fire;

   // Ready depends only on occupancy so decode never reaches back into fetch
   // combinationally.
   assign enq_ready = (count != FULL_CNT);
   assign deq_valid = (count != '0);
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_valid & deq_ready;

   assign deq_insn       = deq_valid ? insn_mem[head_ptr] : NOP_INSN;
   assign deq_pc         = deq_valid ? pc_mem[head_ptr]   : '0;
   assign deq_pred_taken = deq_valid ? pt_mem[head_ptr]   : 1'b0;

   // Storage write on accepted enqueue; contents are not reset.
   always_ff @(posedge clk) begin
      if (enq_fire && !flush) begin
         insn_mem[tail_ptr] <= enq_insn;
         pc_mem[tail_ptr]   <= enq_pc;
         pt_mem[tail_ptr]   <= enq_pred_taken;
      end
   end

   // Pointer and occupancy update; flush overrides both handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (enq_fire) tail_ptr <= tail_ptr + PTR_W'(1);
         if (deq_fire) head_ptr <= head_ptr + PTR_W'(1);
         case ({enq_fire, deq_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
